// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, one-shot/periodic modes, a terminal-count
// pulse and a sticky done flag. All state advances on the falling edge of clk.
module countdown_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int PWIDTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [PWIDTH-1:0] PRESC_LAST = PWIDTH'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]  COUNT_ONE  = WIDTH'(1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  reload_q, reload_d;
    logic [PWIDTH-1:0] presc_q, presc_d;
    logic              tc_q, tc_d;
    logic              done_q, done_d;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        tc_d     = 1'b0;
        done_d   = done_q & ~ack;

        if (load) begin
            reload_d = load_value;
            count_d  = load_value;
            presc_d  = '0;
            done_d   = 1'b0;
            state_d  = ST_IDLE;
        end else if (stop) begin
            // A stop also masks a simultaneous start outside RUN.
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end
        end else if (start && state_q != ST_RUN) begin
            if (count_q != '0) begin
                state_d = ST_RUN;
                presc_d = '0;
            end else begin
                state_d = ST_DONE;
                tc_d    = 1'b1;
                done_d  = 1'b1;
            end
        end else if (state_q == ST_RUN && enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (count_q == COUNT_ONE) begin
                    tc_d   = 1'b1;
                    done_d = 1'b1;
                    if (periodic && reload_q != '0) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = ST_DONE;
                    end
                end else if (count_q != '0) begin
                    count_d = count_q - COUNT_ONE;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = done_q;
    assign busy  = (state_q == ST_RUN);

endmodule
